// File: rtl/dac_spi_pkg.sv
`default_nettype none
// ============================================================================
// Module   : dac_spi_pkg
// Purpose  : Shared definitions for the Pmod DAC SPI responder. Holds the
//            command codes, the broadcast address, the frame field bit
//            positions, the nominal frame length and the receive FSM states.
// Ports    : none (package)
// Revision : 1.0 - initial release
// ============================================================================
package dac_spi_pkg;

  localparam int FRAME_BITS = 32;

  // Command codes carried in the cmd field
  localparam logic [3:0] CMD_WR_IN      = 4'h0;  // write input register
  localparam logic [3:0] CMD_UPD        = 4'h1;  // copy input -> DAC register
  localparam logic [3:0] CMD_WR_UPD_ALL = 4'h2;  // write input, update all DACs
  localparam logic [3:0] CMD_WR_UPD     = 4'h3;  // write input and DAC register

  // Address value that selects every channel at once
  localparam logic [3:0] ADDR_ALL = 4'hF;

  // Field positions inside a 32-bit frame (bit 0 = last bit shifted in)
  localparam int CMD_MSB  = 27;
  localparam int CMD_LSB  = 24;
  localparam int ADDR_MSB = 23;
  localparam int ADDR_LSB = 20;
  localparam int DATA_MSB = 19;
  localparam int DATA_LSB = 8;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    CHECK = 2'd2
  } rx_state_t;

endpackage
`default_nettype wire

// File: rtl/spi_in_sync.sv
`default_nettype none
// ============================================================================
// Module   : spi_in_sync
// Purpose  : Multi-flop synchronizer for one asynchronous SPI pin, followed
//            by rising/falling edge detection on the synchronized level.
// Ports    : clk, reset (async, active-high), clk_enb (state holds when 0)
//            din   - raw pin
//            dout  - synchronized level
//            rise  - synchronized level went 0 -> 1 (one enabled cycle)
//            fall  - synchronized level went 1 -> 0 (one enabled cycle)
// Revision : 1.0 - initial release
// ============================================================================
module spi_in_sync #(
  parameter int   SYNC_STAGES = 2,
  parameter logic RESET_VAL   = 1'b0
) (
  input  logic clk,
  input  logic reset,
  input  logic clk_enb,
  input  logic din,
  output logic dout,
  output logic rise,
  output logic fall
);

  logic [SYNC_STAGES-1:0] r_sync;
  logic                   r_prev;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_sync <= {SYNC_STAGES{RESET_VAL}};
      r_prev <= RESET_VAL;
    end else if (clk_enb) begin
      r_sync <= {r_sync[SYNC_STAGES-2:0], din};
      r_prev <= r_sync[SYNC_STAGES-1];
    end
  end

  assign dout = r_sync[SYNC_STAGES-1];
  assign rise = dout & ~r_prev;
  assign fall = ~dout & r_prev;

endmodule
`default_nettype wire

// File: rtl/dac_spi_rx.sv
`default_nettype none
// ============================================================================
// Module   : dac_spi_rx
// Purpose  : SPI responder modelling the Pmod DAC. Oversamples the SPI pins
//            on clk, captures frames, decodes cmd/addr/data and maintains
//            per-channel input and DAC registers for loopback checking.
// Ports    : clk, reset (async, active-high), clk_enb (state holds when 0)
//            PMOD_MOSI/SCLK/CS_N/LDAC - SPI link pins (CPOL=0, MSB first)
//            rd_ch       - readback channel select
//            dac_value   - dac_reg[rd_ch], combinational
//            frame_valid - pulse, well-formed frame decoded
//            frame_cmd/frame_addr/frame_data - fields of last valid frame
//            frame_err   - pulse, bad bit count / command / address
//            frame_cnt, err_cnt - statistics counters
// Config   : define DAC_RX_STATS_EN to build the saturating frame/error
//            counters; otherwise frame_cnt and err_cnt are tied to 0.
// Revision : 1.0 - initial release
// ============================================================================
module dac_spi_rx
  import dac_spi_pkg::*;
#(
  parameter int SYNC_STAGES = 2,
  parameter int FRAME_BITS  = dac_spi_pkg::FRAME_BITS,
  parameter int NUM_CH      = 8,
  parameter int DATA_W      = 12
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              clk_enb,
  input  logic              PMOD_MOSI,
  input  logic              PMOD_SCLK,
  input  logic              PMOD_CS_N,
  input  logic              PMOD_LDAC,
  input  logic [2:0]        rd_ch,
  output logic [DATA_W-1:0] dac_value,
  output logic              frame_valid,
  output logic [3:0]        frame_cmd,
  output logic [3:0]        frame_addr,
  output logic [DATA_W-1:0] frame_data,
  output logic              frame_err,
  output logic [15:0]       frame_cnt,
  output logic [15:0]       err_cnt
);

  // Counter must hold FRAME_BITS+1 so over-long frames stay distinguishable
  localparam int                c_cnt_w    = $clog2(FRAME_BITS + 2);
  localparam logic [c_cnt_w-1:0] c_cnt_sat  = c_cnt_w'(FRAME_BITS + 1);
  localparam logic [c_cnt_w-1:0] c_cnt_full = c_cnt_w'(FRAME_BITS);

  // --------------------------------------------------------------------------
  // Pin synchronizers
  // --------------------------------------------------------------------------
  logic w_mosi, w_mosi_rise, w_mosi_fall;
  logic w_sclk, w_sclk_rise, w_sclk_fall;
  logic w_cs_n, w_cs_rise, w_cs_fall;
  logic w_ldac_n, w_ldac_rise, w_ldac_fall;

  spi_in_sync #(.SYNC_STAGES(SYNC_STAGES), .RESET_VAL(1'b0)) u_sync_mosi (
    .clk(clk), .reset(reset), .clk_enb(clk_enb), .din(PMOD_MOSI),
    .dout(w_mosi), .rise(w_mosi_rise), .fall(w_mosi_fall)
  );

  spi_in_sync #(.SYNC_STAGES(SYNC_STAGES), .RESET_VAL(1'b0)) u_sync_sclk (
    .clk(clk), .reset(reset), .clk_enb(clk_enb), .din(PMOD_SCLK),
    .dout(w_sclk), .rise(w_sclk_rise), .fall(w_sclk_fall)
  );

  spi_in_sync #(.SYNC_STAGES(SYNC_STAGES), .RESET_VAL(1'b1)) u_sync_cs (
    .clk(clk), .reset(reset), .clk_enb(clk_enb), .din(PMOD_CS_N),
    .dout(w_cs_n), .rise(w_cs_rise), .fall(w_cs_fall)
  );

  spi_in_sync #(.SYNC_STAGES(SYNC_STAGES), .RESET_VAL(1'b1)) u_sync_ldac (
    .clk(clk), .reset(reset), .clk_enb(clk_enb), .din(PMOD_LDAC),
    .dout(w_ldac_n), .rise(w_ldac_rise), .fall(w_ldac_fall)
  );

  // --------------------------------------------------------------------------
  // Receive FSM
  // --------------------------------------------------------------------------
  rx_state_t r_state, w_state_nxt;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state <= IDLE;
    end else if (clk_enb) begin
      r_state <= w_state_nxt;
    end
  end

  // CS_N rising while not shifting falls through the default hold
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      IDLE:    if (w_cs_fall) w_state_nxt = SHIFT;
      SHIFT:   if (w_cs_rise) w_state_nxt = CHECK;
      CHECK:   w_state_nxt = IDLE;
      default: w_state_nxt = IDLE;
    endcase
  end

  // --------------------------------------------------------------------------
  // Shift register and bit counter
  // --------------------------------------------------------------------------
  logic [FRAME_BITS-1:0] r_shift;
  logic [c_cnt_w-1:0]    r_cnt;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_shift <= '0;
      r_cnt   <= '0;
    end else if (clk_enb) begin
      if ((r_state == IDLE) && w_cs_fall) begin
        r_shift <= '0;
        r_cnt   <= '0;
      end else if ((r_state == SHIFT) && w_sclk_rise) begin
        r_shift <= {r_shift[FRAME_BITS-2:0], w_mosi};
        if (r_cnt != c_cnt_sat) r_cnt <= r_cnt + 1'b1;
      end
    end
  end

  // --------------------------------------------------------------------------
  // Frame decode (meaningful only in CHECK)
  // --------------------------------------------------------------------------
  logic [3:0]        w_cmd;
  logic [3:0]        w_addr;
  logic [DATA_W-1:0] w_data;
  logic              w_check, w_len_ok, w_cmd_ok, w_addr_ok, w_good, w_bad;

  assign w_cmd     = r_shift[CMD_MSB:CMD_LSB];
  assign w_addr    = r_shift[ADDR_MSB:ADDR_LSB];
  assign w_data    = r_shift[DATA_LSB +: DATA_W];
  assign w_check   = (r_state == CHECK);
  assign w_len_ok  = (r_cnt == c_cnt_full);
  assign w_cmd_ok  = (w_cmd <= CMD_WR_UPD);
  assign w_addr_ok = (w_addr == ADDR_ALL) || (32'(w_addr) < NUM_CH);
  assign w_good    = w_check && w_len_ok && w_cmd_ok && w_addr_ok;
  // An empty frame (CS_N toggled with no clocks) is dropped silently
  assign w_bad     = w_check && (r_cnt != '0) && !(w_len_ok && w_cmd_ok && w_addr_ok);

  // --------------------------------------------------------------------------
  // Per-channel write enables
  // --------------------------------------------------------------------------
  logic [NUM_CH-1:0] w_sel;
  logic [NUM_CH-1:0] w_in_we;
  logic [NUM_CH-1:0] w_dac_we;
  logic [DATA_W-1:0] w_dac_wd [NUM_CH];
  logic [DATA_W-1:0] r_input  [NUM_CH];
  logic [DATA_W-1:0] r_dac    [NUM_CH];

  for (genvar gi = 0; gi < NUM_CH; gi++) begin : g_ch
    assign w_sel[gi]    = (w_addr == ADDR_ALL) || (w_addr == 4'(gi));
    assign w_in_we[gi]  = w_good && w_sel[gi] && (w_cmd != CMD_UPD);
    assign w_dac_we[gi] = w_good && ((w_cmd == CMD_WR_UPD_ALL) ||
                          (w_sel[gi] && ((w_cmd == CMD_UPD) || (w_cmd == CMD_WR_UPD))));
    // DAC load value sees the word being written this cycle, so the
    // write-and-update commands land in one step
    assign w_dac_wd[gi] = w_in_we[gi] ? w_data : r_input[gi];
  end

  // Explicit DAC writes beat the LDAC copy; the LDAC copy always uses the
  // input register value from before this cycle's write.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < NUM_CH; i++) begin
        r_input[i] <= '0;
        r_dac[i]   <= '0;
      end
    end else if (clk_enb) begin
      for (int i = 0; i < NUM_CH; i++) begin
        if (w_in_we[i]) r_input[i] <= w_data;
        if (w_dac_we[i])    r_dac[i] <= w_dac_wd[i];
        else if (!w_ldac_n) r_dac[i] <= r_input[i];
      end
    end
  end

  always_comb begin
    dac_value = '0;
    if (32'(rd_ch) < NUM_CH) dac_value = r_dac[rd_ch];
  end

  // --------------------------------------------------------------------------
  // Frame result outputs
  // --------------------------------------------------------------------------
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      frame_valid <= 1'b0;
      frame_err   <= 1'b0;
      frame_cmd   <= '0;
      frame_addr  <= '0;
      frame_data  <= '0;
    end else if (clk_enb) begin
      frame_valid <= w_good;
      frame_err   <= w_bad;
      if (w_good) begin
        frame_cmd  <= w_cmd;
        frame_addr <= w_addr;
        frame_data <= w_data;
      end
    end
  end

  // --------------------------------------------------------------------------
  // Statistics
  // --------------------------------------------------------------------------
`ifdef DAC_RX_STATS_EN
  logic [15:0] r_frame_cnt;
  logic [15:0] r_err_cnt;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_frame_cnt <= '0;
      r_err_cnt   <= '0;
    end else if (clk_enb) begin
      if (frame_valid && (r_frame_cnt != 16'hFFFF)) r_frame_cnt <= r_frame_cnt + 16'd1;
      if (frame_err && (r_err_cnt != 16'hFFFF))     r_err_cnt   <= r_err_cnt + 16'd1;
    end
  end

  assign frame_cnt = r_frame_cnt;
  assign err_cnt   = r_err_cnt;
`else
  assign frame_cnt = '0;
  assign err_cnt   = '0;
`endif

  // Don't-care frame bits and unneeded edge detects
  logic w_unused;
  assign w_unused = ^{r_shift[FRAME_BITS-1:CMD_MSB+1], r_shift[DATA_LSB-1:0],
                      w_mosi_rise, w_mosi_fall, w_sclk, w_sclk_fall, w_cs_n,
                      w_ldac_rise, w_ldac_fall};

endmodule
`default_nettype wire

// File: tb/tb_dac_spi_rx.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module   : tb_dac_spi_rx
// Purpose  : Self-checking bench for dac_spi_rx. Stimulus pushes the expected
//            frame result into a queue; a monitor pops and compares whenever
//            the DUT pulses frame_valid or frame_err. Register readbacks are
//            compared directly against hand-computed values.
// Revision : 1.0 - initial release
// ============================================================================
module tb_dac_spi_rx;

  localparam int LAT = 4;  // SYNC_STAGES + 2

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        clk_enb = 1'b1;
  logic        mosi = 1'b0;
  logic        sclk = 1'b0;
  logic        cs_n = 1'b1;
  logic        ldac_n = 1'b1;
  logic [2:0]  rd_ch = 3'd0;
  logic [11:0] dac_value;
  logic        frame_valid;
  logic [3:0]  frame_cmd;
  logic [3:0]  frame_addr;
  logic [11:0] frame_data;
  logic        frame_err;
  logic [15:0] frame_cnt;
  logic [15:0] err_cnt;

  dac_spi_rx u_dut (
    .clk(clk), .reset(reset), .clk_enb(clk_enb),
    .PMOD_MOSI(mosi), .PMOD_SCLK(sclk), .PMOD_CS_N(cs_n), .PMOD_LDAC(ldac_n),
    .rd_ch(rd_ch), .dac_value(dac_value),
    .frame_valid(frame_valid), .frame_cmd(frame_cmd), .frame_addr(frame_addr),
    .frame_data(frame_data), .frame_err(frame_err),
    .frame_cnt(frame_cnt), .err_cnt(err_cnt)
  );

  always #5 clk = ~clk;

  int unsigned cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    logic        err;
    logic [3:0]  cmd;
    logic [3:0]  addr;
    logic [11:0] data;
    int unsigned cyc;
  } exp_t;

  exp_t exp_q[$];
  exp_t mon_e;
  int   n_pass = 0;
  int   n_total = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    n_total++;
    if (act === req) n_pass++;
    else $display("FAIL %s: got 0x%0h, required 0x%0h", name, act, req);
  endtask

  // Scoreboard monitor
  always @(negedge clk) begin
    if (!reset && (frame_valid || frame_err)) begin
      if (exp_q.size() == 0) begin
        n_total++;
        $display("FAIL unexpected_pulse: valid=%0b err=%0b, required no pulse",
                 frame_valid, frame_err);
      end else begin
        mon_e = exp_q.pop_front();
        check("pulse_kind{err,valid}", {30'd0, frame_err, frame_valid},
              {30'd0, mon_e.err, ~mon_e.err});
        if (!mon_e.err)
          check("frame_fields{cmd,addr,data}", {12'd0, frame_cmd, frame_addr, frame_data},
                {12'd0, mon_e.cmd, mon_e.addr, mon_e.data});
        check("pulse_latency", cyc - mon_e.cyc, LAT);
      end
    end
  end

  task automatic wait_cyc(input int n);
    repeat (n) @(negedge clk);
  endtask

  // kind: 0 = valid expected, 1 = error expected, 2 = no pulse expected
  task automatic send(input logic [63:0] w, input int n, input int kind,
                      input logic [3:0] cmd, input logic [3:0] addr, input logic [11:0] data);
    exp_t e;
    cs_n = 1'b0;
    wait_cyc(4);
    for (int i = n - 1; i >= 0; i--) begin
      mosi = w[i];
      wait_cyc(4);
      sclk = 1'b1;
      wait_cyc(4);
      sclk = 1'b0;
    end
    wait_cyc(4);
    if (kind != 2) begin
      e.err = (kind == 1);
      e.cmd = cmd;
      e.addr = addr;
      e.data = data;
      e.cyc = cyc;
      exp_q.push_back(e);
    end
    cs_n = 1'b1;
    wait_cyc(12);
  endtask

  task automatic rd(input int ch, input logic [11:0] req);
    rd_ch = 3'(ch);
    #1;
    check($sformatf("dac_value[%0d]", ch), {20'd0, dac_value}, {20'd0, req});
  endtask

  task automatic ldac_pulse();
    ldac_n = 1'b0;
    wait_cyc(3);
    ldac_n = 1'b1;
    wait_cyc(6);
  endtask

  initial begin
    wait_cyc(3);
    reset = 1'b0;
    wait_cyc(2);
    // Reset state
    check("reset_pulses", {30'd0, frame_valid, frame_err}, 32'd0);
    check("reset_fields", {12'd0, frame_cmd, frame_addr, frame_data}, 32'd0);
    rd(0, 12'h000);

    // cmd 3 to channel 5
    send({32'd0, 32'h035ABC00}, 32, 0, 4'h3, 4'h5, 12'hABC);
    for (int c = 0; c < 8; c++) rd(c, (c == 5) ? 12'hABC : 12'h000);

    // cmd 0 to channel 2 stays in input reg until LDAC
    send({32'd0, 32'h00212300}, 32, 0, 4'h0, 4'h2, 12'h123);
    rd(2, 12'h000);
    ldac_pulse();
    rd(2, 12'h123);
    rd(5, 12'hABC);
    rd(0, 12'h000);

    // Broadcast write/update
    send({32'd0, 32'h03F80000}, 32, 0, 4'h3, 4'hF, 12'h800);
    for (int c = 0; c < 8; c++) rd(c, 12'h800);

    // Short frame, unsupported cmd, out-of-range address: all errors
    send({40'd0, 24'h033123}, 24, 1, 4'h0, 4'h0, 12'h000);
`ifdef DAC_RX_STATS_EN
    check("err_cnt_after_short", {16'd0, err_cnt}, 32'd1);
    check("frame_cnt_after_short", {16'd0, frame_cnt}, 32'd3);
`else
    check("err_cnt_after_short", {16'd0, err_cnt}, 32'd0);
    check("frame_cnt_after_short", {16'd0, frame_cnt}, 32'd0);
`endif
    send({32'd0, 32'h07412300}, 32, 1, 4'h0, 4'h0, 12'h000);
    send({32'd0, 32'h03912300}, 32, 1, 4'h0, 4'h0, 12'h000);
    // LDAC exposes any stray input-register write from the bad frames
    ldac_pulse();
    for (int c = 0; c < 8; c++) rd(c, 12'h800);
    check("last_valid_held", {24'd0, frame_cmd, frame_addr}, 32'h3F);

    // cmd 0 then cmd 1 on channel 6
    send({32'd0, 32'h0065A500}, 32, 0, 4'h0, 4'h6, 12'h5A5);
    rd(6, 12'h800);
    send({32'd0, 32'h01600000}, 32, 0, 4'h1, 4'h6, 12'h000);
    rd(6, 12'h5A5);

    // cmd 2: write channel 7 then update every DAC from input regs
    send({32'd0, 32'h02712300}, 32, 0, 4'h2, 4'h7, 12'h123);
    rd(7, 12'h123);
    rd(6, 12'h5A5);
    rd(0, 12'h800);

    // Over-long frame (counter saturates) and empty frame
    send({30'd0, 32'h03112300, 2'b00}, 34, 1, 4'h0, 4'h0, 12'h000);
    rd(1, 12'h800);
    send(64'd0, 0, 2, 4'h0, 4'h0, 12'h000);

    // Reset in the middle of a frame
    cs_n = 1'b0;
    wait_cyc(4);
    for (int i = 31; i >= 22; i--) begin
      mosi = 32'h03112300 >> i;
      wait_cyc(4);
      sclk = 1'b1;
      wait_cyc(4);
      sclk = 1'b0;
    end
    reset = 1'b1;
    cs_n = 1'b1;
    mosi = 1'b0;
    wait_cyc(3);
    reset = 1'b0;
    wait_cyc(6);
    for (int c = 0; c < 8; c++) rd(c, 12'h000);
    check("fields_after_reset", {12'd0, frame_cmd, frame_addr, frame_data}, 32'd0);

    send({32'd0, 32'h03112300}, 32, 0, 4'h3, 4'h1, 12'h123);
    rd(1, 12'h123);
    rd(0, 12'h000);

    wait_cyc(20);
    check("scoreboard_drained", exp_q.size(), 32'd0);
`ifdef DAC_RX_STATS_EN
    check("final_frame_cnt", {16'd0, frame_cnt}, 32'd1);
    check("final_err_cnt", {16'd0, err_cnt}, 32'd0);
`else
    check("final_frame_cnt", {16'd0, frame_cnt}, 32'd0);
    check("final_err_cnt", {16'd0, err_cnt}, 32'd0);
`endif
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
`default_nettype wire
